imem_boot_loader: RTL and testbench

//  Upstream stage of Single_cycle_top. Streams a program over a valid/ready word interface into instruction memory.

---
 rtl/boot_pkg.sv | 15 +
 rtl/boot_release_timer.sv | 33 +++
 rtl/imem_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and default sizes for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CSUM    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } boot_state_t;

  localparam int BOOT_ADDR_W = 8;
  localparam int BOOT_LEN_W  = BOOT_ADDR_W + 1;

endpackage

// File: rtl/boot_release_timer.sv
// Counts down RUN_DELAY cycles after a load; expire_o marks the last counted cycle.
module boot_release_timer #(
  parameter int RUN_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expire_o
);

  localparam int CW = $clog2(RUN_DELAY + 1);
  localparam logic [CW-1:0] DELAY = CW'(RUN_DELAY);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] ZERO  = CW'(0);

  logic [CW-1:0] cnt_q;

  // Reload on request, otherwise count down to zero and park there.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ZERO;
    end else if (load_i) begin
      cnt_q <= DELAY;
    end else if (cnt_q != ZERO) begin
      cnt_q <= cnt_q - ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = (cnt_q == ONE);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory and holds the core in reset until it is loaded.
// Optional trailing checksum word is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = BOOT_ADDR_W,
  parameter int DATA_WIDTH = 32,
  parameter int RUN_DELAY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0]   CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  boot_state_t           state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  s_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [DATA_WIDTH-1:0] imem_wdata_q;
  logic                  core_rst_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic hs;
  logic len_ok;
  logic last_word;
  logic tmr_load;
  logic tmr_expire;

  assign hs        = s_valid && s_ready_q;
  assign len_ok    = (len != LEN_ZERO) && (len <= CAPACITY);
  // Count is kept one bit narrower than len; compare against len-1 so a full fill never wraps.
  assign last_word = ({1'b0, count_q} == (len_q - LEN_ONE));

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] sum_d;
  logic                  csum_ok;

  assign sum_d    = sum_q + s_data;
  assign csum_ok  = (sum_d == DATA_ZERO);
  assign tmr_load = (state_q == CSUM) && hs && csum_ok;
`else
  assign tmr_load = (state_q == LOAD) && hs && last_word;
`endif

  boot_release_timer #(
    .RUN_DELAY (RUN_DELAY)
  ) u_release_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .expire_o (tmr_expire)
  );

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= LEN_ZERO;
      count_q      <= ADDR_ZERO;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= ADDR_ZERO;
      imem_wdata_q <= DATA_ZERO;
      core_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q        <= DATA_ZERO;
`endif
    end else begin
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            if (len_ok) begin
              state_q    <= LOAD;
              len_q      <= len;
              count_q    <= ADDR_ZERO;
              s_ready_q  <= 1'b1;
              busy_q     <= 1'b1;
              core_rst_q <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
              sum_q      <= DATA_ZERO;
`endif
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= count_q;
            imem_wdata_q <= s_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
            if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              state_q   <= CSUM;
`else
              state_q   <= RELEASE;
              s_ready_q <= 1'b0;
`endif
            end else begin
              count_q <= count_q + ADDR_ONE;
            end
          end
        end
        CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          if (hs) begin
            s_ready_q <= 1'b0;
            if (csum_ok) begin
              state_q <= RELEASE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
`else
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
`endif
        end
        RELEASE: begin
          if (tmr_expire) begin
            state_q    <= RUN;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          s_ready_q  <= 1'b0;
          busy_q     <= 1'b0;
          core_rst_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against an address/data/timing model.
module tb_imem_boot_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          error;

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RUN_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: shadow of imem as seen through the write port.
  logic [DW-1:0] dut_mem [0:255];
  int            wr_addr [$];
  int            wr_cyc  [$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      dut_mem[imem_addr] = imem_wdata;
      wr_addr.push_back(int'(imem_addr));
      wr_cyc.push_back(cyc);
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_mem [0:255];
  logic [DW-1:0] wq [$];
  int            acc_cyc [$];
  int            last_acc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [AW:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] neg_sum(input int n);
    logic [DW-1:0] s = 32'd0;
    for (int i = 0; i < n; i++) s = s + wq[i];
    return 32'd0 - s;
  endfunction

  // Drive every word of wq with random idle gaps; record acceptance cycles.
  task automatic send_words(input int gmin, input int gmax);
    int waited;
    for (int i = 0; i < wq.size(); i++) begin
      int gaps = int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        tick();
      end
      s_valid = 1'b1;
      s_data  = wq[i];
      waited  = 0;
      while (s_ready !== 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      if (waited >= 50) begin
        check_eq("accept_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        return;
      end
      tick();
      last_acc = cyc;
      acc_cyc.push_back(cyc);
    end
    s_valid = 1'b0;
  endtask

  task automatic expect_release(input string tag);
    int w = 0;
    while (core_rst !== 1'b1 && w < RD + 10) begin
      tick();
      w++;
    end
    check_eq({tag, "_rel_delay"}, 64'(cyc - last_acc), 64'(RD));
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_busy_run"}, busy, 1'b0);
    tick();
    check_eq({tag, "_done_pulse"}, done, 1'b0);
    check_eq({tag, "_core_run"}, core_rst, 1'b1);
  endtask

  // n data words (wq may carry one extra checksum word); ok selects release vs error.
  task automatic do_load(input int n, input int gmin, input int gmax, input bit ok, input string tag);
    int base = wr_addr.size();
    acc_cyc.delete();
    issue_start((AW + 1)'(n));
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_ready"}, s_ready, 1'b1);
    check_eq({tag, "_core_held"}, core_rst, 1'b0);
    send_words(gmin, gmax);
    for (int j = 0; j < n; j++) exp_mem[j] = wq[j];
    if (ok) begin
      expect_release(tag);
    end else begin
      check_eq({tag, "_err"}, error, 1'b1);
      check_eq({tag, "_err_busy"}, busy, 1'b0);
      tick();
      tick();
      check_eq({tag, "_err_core"}, core_rst, 1'b0);
    end
    check_eq({tag, "_nwrites"}, 64'(wr_addr.size() - base), 64'(n));
    for (int j = 0; j < n && base + j < wr_addr.size() && j < acc_cyc.size(); j++) begin
      check_eq({tag, "_waddr"}, 64'(wr_addr[base + j]), 64'(j));
      check_eq({tag, "_wcyc"}, 64'(wr_cyc[base + j]), 64'(acc_cyc[j]));
      check_eq({tag, "_wdata"}, dut_mem[j], exp_mem[j]);
    end
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; start = 1'b0; len = 9'd0; s_valid = 1'b0; s_data = 32'd0;
    tick();
    tick();
    check_eq("rst_s_ready", s_ready, 1'b0);
    check_eq("rst_imem_we", imem_we, 1'b0);
    check_eq("rst_imem_addr", imem_addr, 8'd0);
    check_eq("rst_imem_wdata", imem_wdata, 32'd0);
    check_eq("rst_core_rst", core_rst, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    rst = 1'b0;

    // Stream words are ignored while idle.
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    tick();
    check_eq("idle_ready", s_ready, 1'b0);
    s_valid = 1'b0;

    // Out-of-range lengths from IDLE.
    base = wr_addr.size();
    issue_start(9'd0);
    check_eq("len0_err", error, 1'b1);
    check_eq("len0_busy", busy, 1'b0);
    tick();
    check_eq("len0_pulse", error, 1'b0);
    issue_start(9'd257);
    check_eq("len257_err", error, 1'b1);
    tick();
    check_eq("len257_core", core_rst, 1'b0);
    check_eq("badlen_nowrite", 64'(wr_addr.size() - base), 64'd0);

    wq = '{32'h00500093, 32'h00A00113, 32'h002081B3};
`ifdef IMEM_BOOT_CHECKSUM_EN
    wq.push_back(neg_sum(3));
`endif
    do_load(3, 0, 0, 1'b1, "b2b");
    do_load(3, 4, 4, 1'b1, "gap4");

    // Bad length while running keeps the core running.
    issue_start(9'd0);
    check_eq("run_len0_err", error, 1'b1);
    check_eq("run_len0_core", core_rst, 1'b1);
    tick();

    wq = '{32'h00000013};
`ifdef IMEM_BOOT_CHECKSUM_EN
    wq.push_back(neg_sum(1));
`endif
    do_load(1, 0, 0, 1'b1, "reload1");

    // Abort after two words of a four-word load.
    base = wr_addr.size();
    issue_start(9'd4);
    wq = '{$urandom, $urandom};
    send_words(0, 1);
    exp_mem[0] = wq[0];
    exp_mem[1] = wq[1];
    s_valid = 1'b1; s_data = $urandom; rst = 1'b1;
    tick();
    check_eq("abort_core", core_rst, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ready", s_ready, 1'b0);
    s_valid = 1'b0; start = 1'b1; len = 9'd4;
    tick();
    start = 1'b0; rst = 1'b0;
    repeat (RD + 3) tick();
    check_eq("abort_start_ign", busy, 1'b0);
    check_eq("abort_no_release", core_rst, 1'b0);
    check_eq("abort_nwrites", 64'(wr_addr.size() - base), 64'd2);
    check_eq("abort_w0", dut_mem[0], exp_mem[0]);
    check_eq("abort_w1", dut_mem[1], exp_mem[1]);
    wq = '{$urandom, $urandom, $urandom, $urandom};
`ifdef IMEM_BOOT_CHECKSUM_EN
    wq.push_back(neg_sum(4));
`endif
    do_load(4, 0, 2, 1'b1, "after_abort");

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(24, 1));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
`ifdef IMEM_BOOT_CHECKSUM_EN
      wq.push_back(neg_sum(n));
`endif
      do_load(n, 0, 3, 1'b1, "rand");
    end

    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
`ifdef IMEM_BOOT_CHECKSUM_EN
    wq.push_back(neg_sum(256));
`endif
    do_load(256, 0, 1, 1'b1, "full");

`ifdef IMEM_BOOT_CHECKSUM_EN
    wq = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFA};
    do_load(3, 0, 1, 1'b1, "csum_ok");
    wq = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFB};
    do_load(3, 0, 1, 1'b0, "csum_bad");
`endif

    for (int a = 0; a < 256; a++) check_eq("final_mem", dut_mem[a], exp_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
